// File: rtl/core_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a fast path for divide-by-zero and signed overflow.
module core_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [2:0]      func_in,
  input  logic [XLEN-1:0] opnum1_in,
  input  logic [XLEN-1:0] opnum2_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            valid_out,
  output logic [XLEN-1:0] res_out
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        func_q;
  logic [XLEN-1:0]   mag1, mag2;
  logic              neg_a, neg_b;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;

  logic            accept, sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] in_mag1, in_mag2;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  assign busy_out  = (state == CALC) || (state == FIX);
  assign valid_out = (state == DONE);
  assign accept    = start_in & ~busy_out & ~flush_in;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (func_in)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'b010:                         sgn1 = 1'b1;
      default: ;
    endcase
  end

  assign s1      = sgn1 & opnum1_in[XLEN-1];
  assign s2      = sgn2 & opnum2_in[XLEN-1];
  assign in_mag1 = s1 ? -opnum1_in : opnum1_in;
  assign in_mag2 = s2 ? -opnum2_in : opnum2_in;

  assign div_zero = func_in[2] & (opnum2_in == '0);
  assign div_ovf  = func_in[2] & ~func_in[0]
                  & (opnum1_in == {1'b1, {(XLEN-1){1'b0}}}) & (opnum2_in == '1);
  assign fast     = div_zero | div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero)     fast_res = func_in[1] ? opnum1_in : '1;
    else if (div_ovf) fast_res = func_in[1] ? '0 : opnum1_in;
  end

  // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag1} : '0);
  assign mul_step = {mul_sum, acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  logic [XLEN:0]     div_rem, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_step;
  assign div_rem  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_rem - {1'b0, mag2};
  assign div_ge   = ~div_diff[XLEN];
  assign div_step = {(div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]), acc[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, remd, fix_res;
  assign prod = neg_a ? -acc : acc;
  assign quo  = neg_a ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign remd = neg_b ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (func_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = remd;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = fast ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (cnt == CW'(XLEN - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush_in) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      func_q  <= '0;
      mag1    <= '0;
      mag2    <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      res_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        func_q <= func_in;
        mag1   <= in_mag1;
        mag2   <= in_mag2;
        neg_a  <= s1 ^ s2;
        neg_b  <= s1;
        cnt    <= '0;
        acc    <= func_in[2] ? {{XLEN{1'b0}}, in_mag1} : {{XLEN{1'b0}}, in_mag2};
        if (fast) res_out <= fast_res;
      end else if (state == CALC && !flush_in) begin
        acc <= func_q[2] ? div_step : mul_step;
        cnt <= cnt + CW'(1);
      end else if (state == FIX && !flush_in) begin
        res_out <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_core_muldiv.sv
// Directed bench for core_muldiv: latency, results, fast path, flush, back-to-back, reset.
module tb_core_muldiv;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, start_in, flush_in;
  logic [2:0]      func_in;
  logic [XLEN-1:0] opnum1_in, opnum2_in;
  logic            busy_out, valid_out;
  logic [XLEN-1:0] res_out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  core_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .func_in   (func_in),
    .opnum1_in (opnum1_in),
    .opnum2_in (opnum2_in),
    .flush_in  (flush_in),
    .busy_out  (busy_out),
    .valid_out (valid_out),
    .res_out   (res_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept at the edge ending cycle T; returns 1ns into cycle T+1 with inputs scrambled.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start_in  = 1'b1;
    func_in   = f;
    opnum1_in = a;
    opnum2_in = b;
    tick();
    start_in  = 1'b0;
    func_in   = ~f;
    opnum1_in = 32'hA5A5_A5A5;
    opnum2_in = 32'h5A5A_5A5A;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(f, a, b);
    for (int i = 1; i <= XLEN + 1; i++) begin
      chk({tag, " busy"}, busy_out, 1);
      chk({tag, " valid_early"}, valid_out, 0);
      tick();
    end
    chk({tag, " valid"}, valid_out, 1);
    chk({tag, " busy_done"}, busy_out, 0);
    chk({tag, " res"}, res_out, exp);
    tick();
    chk({tag, " valid_after"}, valid_out, 0);
    chk({tag, " res_hold"}, res_out, exp);
  endtask

  task automatic fast_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(f, a, b);
    chk({tag, " busy"}, busy_out, 0);
    chk({tag, " valid"}, valid_out, 1);
    chk({tag, " res"}, res_out, exp);
    tick();
    chk({tag, " busy_after"}, busy_out, 0);
    chk({tag, " valid_after"}, valid_out, 0);
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; flush_in = 1'b0;
    func_in = 3'b000; opnum1_in = '0; opnum2_in = '0;
    #2;
    chk("reset busy", busy_out, 0);
    chk("reset valid", valid_out, 0);
    chk("reset res", res_out, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_op("MUL 7*-3",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MULH",       3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("MULHU",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULHSU",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("DIV -7/2",   3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
    run_op("REM -7/2",   3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
    run_op("DIVU 100/7", 3'b101, 32'd100,      32'd7,        32'd14);
    run_op("REMU 100/7", 3'b111, 32'd100,      32'd7,        32'd2);

    fast_op("DIV ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    fast_op("REM ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    fast_op("DIV 5/0",   3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF);
    fast_op("REMU 5/0",  3'b111, 32'd5,        32'd0,        32'd5);

    // Flush during DIVU: raised in cycle T+10, result must stay at 5.
    issue(3'b101, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    chk("flush pre busy", busy_out, 1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("flush busy", busy_out, 0);
    chk("flush valid", valid_out, 0);
    chk("flush res", res_out, 32'd5);
    run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12);
    chk("flush no late valid", valid_out, 0);

    // Start held high: MUL then, in its DONE cycle, DIVU.
    start_in = 1'b1; func_in = 3'b000; opnum1_in = 32'd5; opnum2_in = 32'd6;
    tick();
    for (int i = 1; i <= XLEN + 1; i++) begin
      chk("b2b busy1", busy_out, 1);
      chk("b2b valid1_early", valid_out, 0);
      tick();
    end
    chk("b2b valid1", valid_out, 1);
    chk("b2b res1", res_out, 32'd30);
    func_in = 3'b101; opnum1_in = 32'd100; opnum2_in = 32'd7;
    tick();
    chk("b2b valid1_once", valid_out, 0);
    for (int i = 1; i <= XLEN + 1; i++) begin
      chk("b2b busy2", busy_out, 1);
      chk("b2b valid2_early", valid_out, 0);
      tick();
    end
    chk("b2b valid2", valid_out, 1);
    chk("b2b res2", res_out, 32'd14);
    start_in = 1'b0;
    tick();
    chk("b2b idle busy", busy_out, 0);
    chk("b2b idle valid", valid_out, 0);

    // Asynchronous reset mid-operation.
    issue(3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", busy_out, 0);
    chk("midrst valid", valid_out, 0);
    chk("midrst res", res_out, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst valid", valid_out, 0);
    run_op("DIVU after reset", 3'b101, 32'd100, 32'd7, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
